// File: rtl/fpu_pipe_pkg.sv
// Shared types and format constants for the pipelined filter FPU.
// A float is {sign, biased exponent, stored mantissa}; the hidden one is implicit.
`define FPU_FLOAT_T(EW, MW) struct packed { logic sign; logic [(EW)-1:0] exp; logic [(MW)-1:0] mant; }

package fpu_pipe_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MULT = 2'd2,
        OP_RSVD = 2'd3
    } fpu_op_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
    } fpu_flags_t;

    function automatic int unsigned fpu_bias(input int unsigned exp_w);
        return (2 ** (exp_w - 1)) - 1;
    endfunction

    // First exponent value that no longer fits; saturation stops one below it.
    function automatic int unsigned fpu_exp_lim(input int unsigned exp_w);
        return (2 ** exp_w) - 1;
    endfunction

    function automatic int unsigned fpu_exp_sat(input int unsigned exp_w);
        return (2 ** exp_w) - 2;
    endfunction

endpackage

// File: rtl/fpu_pipe_lzc.sv
// Leading-zero counter used by the FPU normaliser; an all-zero input yields WIDTH.
module fpu_pipe_lzc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] count_o
);

    // Scan upward so the highest set bit is the last assignment to stick.
    always_comb begin
        count_o = CNT_W'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_pipe.sv
// Three-stage ADD/SUB/MULT floating-point pipeline with valid/ready flow control.
// Flush-to-zero, truncating, saturating; no Inf/NaN encodings.
module fpu_pipe
    import fpu_pipe_pkg::*;
#(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                op,
    input  logic [EXP_W+MANT_W:0]     a,
    input  logic [EXP_W+MANT_W:0]     b,
    input  logic [TAG_W-1:0]          tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     result,
    output logic [TAG_W-1:0]          out_tag,
    output logic [2:0]                flags
);

    localparam int unsigned W  = 1 + EXP_W + MANT_W;
    localparam int unsigned NW = MANT_W + 3;        // carry, hidden, fraction, guard
    localparam int unsigned XW = EXP_W + 2;
    localparam int unsigned PW = 2 * MANT_W + 2;
    localparam int unsigned LW = $clog2(NW + 1);

    typedef `FPU_FLOAT_T(EXP_W, MANT_W) float_t;
    typedef logic signed [XW-1:0] sexp_t;

    localparam sexp_t            EXP_LIM   = sexp_t'(fpu_exp_lim(EXP_W));
    localparam sexp_t            BIAS      = sexp_t'(fpu_bias(EXP_W));
    localparam logic [EXP_W-1:0] EXP_SAT   = EXP_W'(fpu_exp_sat(EXP_W));
    localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(NW - 1);

    typedef struct packed {
        logic            mult;
        logic            sa;
        logic            sb;
        logic [NW-2:0]   ma;
        logic [NW-2:0]   mb;
        logic [PW-1:0]   prod;
        sexp_t           exp;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic            sign;
        logic [NW-1:0]   mant;
        sexp_t           exp;
        logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic [W-1:0]    res;
        fpu_flags_t      flags;
        logic [TAG_W-1:0] tag;
    } s3_t;

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s3_t  s3_d, s3_q;
    logic v1_q, v2_q, v3_q;
    logic load1, load2, load3;

    assign load3    = !v3_q || out_ready;
    assign load2    = !v2_q || load3;
    assign load1    = !v1_q || load2;
    assign in_ready = load1;

    // S1: unpack and align
    float_t           fa, fb;
    fpu_op_t          op_e;
    logic             is_mult, is_sub, a_big;
    logic [MANT_W:0]  ha, hb;
    logic [EXP_W-1:0] ediff;
    logic [NW-2:0]    xa, xb;

    assign fa   = a;
    assign fb   = b;
    assign op_e = fpu_op_t'(op);

    always_comb begin
        is_mult = (op_e == OP_MULT);
        is_sub  = (op_e == OP_SUB);
        ha      = (fa.exp == '0) ? '0 : {1'b1, fa.mant};
        hb      = (fb.exp == '0) ? '0 : {1'b1, fb.mant};
        a_big   = fa.exp >= fb.exp;
        ediff   = a_big ? fa.exp - fb.exp : fb.exp - fa.exp;
        xa      = {ha, 1'b0};
        xb      = {hb, 1'b0};
        if (ediff >= SHIFT_LIM) begin
            if (a_big) xb = '0;
            else       xa = '0;
        end else if (a_big) begin
            xb = xb >> ediff;
        end else begin
            xa = xa >> ediff;
        end
        s1_d.mult = is_mult;
        s1_d.sa   = is_mult ? (fa.sign ^ fb.sign) : fa.sign;
        s1_d.sb   = fb.sign ^ is_sub;
        s1_d.ma   = xa;
        s1_d.mb   = xb;
        s1_d.prod = PW'(ha) * PW'(hb);
        s1_d.exp  = is_mult ? sexp_t'({2'b00, fa.exp}) + sexp_t'({2'b00, fb.exp}) - BIAS
                            : sexp_t'({2'b00, a_big ? fa.exp : fb.exp});
        s1_d.tag  = tag;
    end

    // S2: signed-magnitude add, or product pre-normalisation
    logic [PW-1:0] pn;

    always_comb begin
        s2_d     = '0;
        s2_d.tag = s1_q.tag;
        s2_d.exp = s1_q.exp;
        pn       = s1_q.prod;
        if (s1_q.mult) begin
            if (s1_q.prod[PW-1]) begin
                pn       = s1_q.prod >> 1;
                s2_d.exp = s1_q.exp + sexp_t'(1);
            end
            s2_d.mant = {1'b0, pn[PW-2 -: NW-1]};
            s2_d.sign = s1_q.sa;
        end else if (s1_q.sa == s1_q.sb) begin
            s2_d.mant = NW'(s1_q.ma) + NW'(s1_q.mb);
            s2_d.sign = s1_q.sa;
        end else if (s1_q.ma > s1_q.mb) begin
            s2_d.mant = NW'(s1_q.ma) - NW'(s1_q.mb);
            s2_d.sign = s1_q.sa;
        end else if (s1_q.mb > s1_q.ma) begin
            s2_d.mant = NW'(s1_q.mb) - NW'(s1_q.ma);
            s2_d.sign = s1_q.sb;
        end
    end

    // S3: normalise, truncate, exceptions, pack
    logic [LW-1:0] lz;
    logic [NW-1:0] norm;
    sexp_t         exp_n;

    fpu_pipe_lzc #(.WIDTH(NW), .CNT_W(LW)) u_lzc (
        .in_i    (s2_q.mant),
        .count_o (lz)
    );

    always_comb begin
        s3_d     = '0;
        s3_d.tag = s2_q.tag;
        norm     = s2_q.mant << lz;
        exp_n    = s2_q.exp + sexp_t'(1) - sexp_t'(lz);
        if (s2_q.mant == '0) begin
            s3_d.res        = {s2_q.sign, {(W-1){1'b0}}};
            s3_d.flags.zero = 1'b1;
        end else if (exp_n >= EXP_LIM) begin
            s3_d.res       = {s2_q.sign, EXP_SAT, {MANT_W{1'b1}}};
            s3_d.flags.ovf = 1'b1;
        end else if (exp_n <= sexp_t'(0)) begin
            s3_d.res        = {s2_q.sign, {(W-1){1'b0}}};
            s3_d.flags.unf  = 1'b1;
            s3_d.flags.zero = 1'b1;
        end else begin
            s3_d.res = {s2_q.sign, exp_n[EXP_W-1:0], norm[NW-2 -: MANT_W]};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pn[PW-1], pn[MANT_W-2:0], norm[NW-1], norm[1:0]};

    // Data registers only load behind a valid token so a stalled output stays put.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            if (load1) begin
                v1_q <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (load2) begin
                v2_q <= v1_q;
                if (v1_q) s2_q <= s2_d;
            end
            if (load3) begin
                v3_q <= v2_q;
                if (v2_q) s3_q <= s3_d;
            end
        end
    end

    assign out_valid = v3_q;
    assign result    = s3_q.res;
    assign out_tag   = s3_q.tag;
    assign flags     = s3_q.flags;

endmodule

// File: tb/tb_fpu_pipe.sv
// Self-checking bench for fpu_pipe (single-precision layout): directed vectors,
// backpressure, reset mid-flight and a randomized stream against a reference model.
module tb_fpu_pipe;

    logic        clk, rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  op;
    logic [31:0] a, b, result;
    logic [3:0]  tag, out_tag;
    logic [2:0]  flags;
    int          total = 0;
    int          bad   = 0;

    fpu_pipe #(.EXP_W(8), .MANT_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .tag       (tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference: exact integer arithmetic following the format rules, returns {flags, result}.
    function automatic logic [34:0] ref_fpu(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int     ex, ey, e, d;
        longint mx, my, sum, mag;
        logic   sx, sy, s;
        sx = x[31];
        sy = y[31] ^ (o == 2'd1);
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = (ex == 0) ? 64'sd0 : ((longint'(1) << 23) + longint'(x[22:0]));
        my = (ey == 0) ? 64'sd0 : ((longint'(1) << 23) + longint'(y[22:0]));
        if (o == 2'd2) begin
            s   = x[31] ^ y[31];
            mag = mx * my;
            if (mag == 0) return {3'b001, s, 31'd0};
            e = ex + ey - 127;
            if (mag >= (longint'(1) << 47)) begin
                mag = mag >> 1;
                e++;
            end
            mag = mag >> 22;
        end else begin
            mx = mx << 1;
            my = my << 1;
            if (ex >= ey) begin
                e  = ex;
                d  = ex - ey;
                my = (d >= 25) ? 64'sd0 : (my >> d);
            end else begin
                e  = ey;
                d  = ey - ex;
                mx = (d >= 25) ? 64'sd0 : (mx >> d);
            end
            sum = (sx ? -mx : mx) + (sy ? -my : my);
            if (sum == 0) return {3'b001, ((sx == sy) ? sx : 1'b0), 31'd0};
            s   = (sum < 0);
            mag = s ? -sum : sum;
        end
        while (mag >= (longint'(1) << 25)) begin
            mag = mag >> 1;
            e++;
        end
        while (mag < (longint'(1) << 24)) begin
            mag = mag << 1;
            e--;
        end
        if (e >= 255) return {3'b100, s, 8'hFE, 23'h7FFFFF};
        if (e <= 0)   return {3'b011, s, 31'd0};
        return {3'b000, s, 8'(e), 23'((mag >> 1) & 64'h7FFFFF)};
    endfunction

    task automatic rand_pair(output logic [31:0] x, output logic [31:0] y);
        int         k;
        logic [7:0] ex, ey;
        x  = $urandom;
        y  = $urandom;
        k  = $urandom_range(0, 9);
        ex = 8'($urandom_range(100, 154));
        ey = 8'(int'(ex) + int'($urandom_range(0, 30)) - 15);
        case (k)
            0: ex = 8'd0;
            1: begin ex = 8'($urandom_range(240, 255)); ey = 8'($urandom_range(240, 255)); end
            2: begin ex = 8'($urandom_range(1, 12));    ey = 8'($urandom_range(1, 12));    end
            3: begin ey = ex; y[22:0] = x[22:0]; end
            default: ;
        endcase
        x[30:23] = ex;
        y[30:23] = ey;
    endtask

    task automatic run_one(input string name, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [3:0] t,
                           input logic [31:0] want_res, input logic [2:0] want_flags);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = o; a = x; b = y; tag = t;
        #1 check({name, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1 lat++;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_out"}, {out_tag, flags, result}, {t, want_flags, want_res});
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic stream(input int n_ops, input int max_cycles, input bit scripted);
        logic [38:0] sbq[$];
        logic [38:0] held, got, want;
        logic [31:0] x, y;
        bit          holding, saw_stall;
        int          sent, done;
        sent = 0; done = 0; holding = 0; saw_stall = 0; held = '0;
        for (int cyc = 0; cyc < max_cycles && done < n_ops; cyc++) begin
            @(negedge clk);
            out_ready = scripted ? !(cyc >= 4 && cyc <= 9) : ($urandom_range(0, 3) != 0);
            in_valid  = (sent < n_ops) && (scripted || $urandom_range(0, 4) != 0);
            if (in_valid) begin
                rand_pair(x, y);
                a   = x;
                b   = y;
                op  = 2'($urandom_range(0, 3));
                tag = scripted ? 4'(sent) : 4'($urandom);
            end
            #1;
            got = {out_tag, flags, result};
            if (holding) check("hold_stable", {out_valid, got}, {1'b1, held});
            if (out_valid && out_ready) begin
                check("out_expected", 64'(sbq.size() > 0), 64'd1);
                if (sbq.size() > 0) begin
                    want = sbq.pop_front();
                    check(scripted ? "bp_result" : "rand_result", got, want);
                end
                done++;
            end
            holding = out_valid && !out_ready;
            held    = got;
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (in_valid && in_ready) begin
                sbq.push_back({tag, ref_fpu(op, a, b)});
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check(scripted ? "bp_count" : "rand_count", done, n_ops);
        check("leftover", sbq.size(), 0);
        if (scripted) check("bp_in_ready_drop", saw_stall, 1);
        @(posedge clk);
        #1 check("no_duplicate", out_valid, 0);
    endtask

    initial begin
        int stale;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'd0; a = '0; b = '0; tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_out_tag", out_tag, 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        run_one("add_1p5_2p25",  2'd0, 32'h3FC00000, 32'h40100000, 4'h1, 32'h40700000, 3'b000);
        run_one("sub_equal",     2'd1, 32'h40400000, 32'h40400000, 4'h2, 32'h00000000, 3'b001);
        run_one("sub_neg",       2'd1, 32'h3F800000, 32'h40000000, 4'h3, 32'hBF800000, 3'b000);
        run_one("mult_1p5_2",    2'd2, 32'h3FC00000, 32'h40000000, 4'h4, 32'h40400000, 3'b000);
        run_one("mult_ovf",      2'd2, 32'h7F000000, 32'h7F000000, 4'h5, 32'h7F7FFFFF, 3'b100);
        run_one("mult_unf",      2'd2, 32'h00800000, 32'h00800000, 4'h6, 32'h00000000, 3'b011);
        run_one("add_zero",      2'd0, 32'h00000000, 32'hC0A00000, 4'h7, 32'hC0A00000, 3'b000);
        run_one("op3_as_add",    2'd3, 32'h3FC00000, 32'h40100000, 4'h8, 32'h40700000, 3'b000);
        run_one("mult_zero_sgn", 2'd2, 32'h80000000, 32'h40000000, 4'h9, 32'h80000000, 3'b001);

        stream(8, 60, 1'b1);

        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op = 2'd0; a = 32'h3F800000; b = 32'h3F800000; tag = 4'(i);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1 check("inflight_out_valid", out_valid, 1);
        rst = 1'b0;
        #1 check("midrst_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 if (out_valid) stale++;
        end
        check("no_stale_after_rst", stale, 0);
        run_one("post_rst_mult", 2'd2, 32'hC0400000, 32'h40800000, 4'hA, 32'hC1400000, 3'b000);

        stream(300, 3000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
